nonce_report_fifo: RTL and testbench

- Buffers golden nonces from the hashing core and presents the oldest one on a probe word for the JTAG host to poll.
- Sits directly upstream of the virtual wire. probe_data drives the virtual wire's rx_data.
- Host acknowledge bits come back from the virtual wire's tx_data.
- The host pops one entry per ack toggle, so bursts of nonces found between polls are not lost.

---
 rtl/nonce_report_fifo.sv | 113 +++++++++++
 tb/tb_nonce_report_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nonce_report_fifo.sv
// nonce_report_fifo: buffers golden nonces from the hashing core and presents
// the oldest entry, its occupancy and a sticky overflow flag on one probe word.
// The JTAG host pops one entry per level change of host_ack_toggle and clears
// overflow per level change of host_clr_toggle. The probe word comes only from
// registers, so it has no combinational path from any input.
module nonce_report_fifo #(
    parameter int NONCE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              nonce_valid,
    input  logic [NONCE_WIDTH-1:0]            nonce,
    input  logic                              host_ack_toggle,
    input  logic                              host_clr_toggle,
    output logic [NONCE_WIDTH+ADDR_WIDTH+2:0] probe_data
);

    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_COUNT  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [NONCE_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   ack_q, clr_q;
    logic [NONCE_WIDTH-1:0] head_q, head_d;

    logic ack_evt, clr_evt, empty, full;
    logic pop_ok, push_ok, ovf_evt, new_is_head;

    // Decode host requests and compute the next pointer/count/flag/head state.
    always_comb begin
        ack_evt  = host_ack_toggle ^ ack_q;
        clr_evt  = host_clr_toggle ^ clr_q;
        empty    = (count_q == '0);
        full     = (count_q == FULL_COUNT);
        // A pop request against an empty FIFO is simply dropped.
        pop_ok   = ack_evt && !empty;
        // When full, a push is only accepted if a pop frees a slot this cycle.
        push_ok  = nonce_valid && (!full || pop_ok);
        ovf_evt  = nonce_valid && full && !pop_ok;

        wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase

        // Setting overflow takes priority over a clear in the same cycle.
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clr_evt) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        // The incoming nonce becomes head when nothing older survives this edge;
        // it is not yet in memory, so bypass it straight into the head register.
        new_is_head = push_ok && (empty || ((count_q == ONE_COUNT) && pop_ok));
        if (count_d == '0) begin
            head_d = '0;
        end else if (new_is_head) begin
            head_d = nonce;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array; entries need no reset since count qualifies them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= nonce;
        end
    end

    // Control state; toggle trackers reload the live levels on reset so that
    // no spurious pop or clear fires after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            head_q     <= '0;
            ack_q      <= host_ack_toggle;
            clr_q      <= host_clr_toggle;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
            ack_q      <= host_ack_toggle;
            clr_q      <= host_clr_toggle;
        end
    end

    // Probe word, LSB first: head nonce, count, valid, overflow.
    always_comb begin
        probe_data = {overflow_q, (count_q != '0), count_q, head_q};
    end

endmodule

// File: tb/tb_nonce_report_fifo.sv
// tb_nonce_report_fifo: table-driven vectors plus hand-written sequences.
// Every driven cycle pushes the model's expected probe word to a queue; the
// word is popped and compared against the DUT just after the clock edge.
module tb_nonce_report_fifo;

    localparam int NW = 32;
    localparam int AW = 3;
    localparam int PW = NW + AW + 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          nonce_valid;
    logic [NW-1:0] nonce;
    logic          host_ack_toggle;
    logic          host_clr_toggle;
    logic [PW-1:0] probe_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [NW-1:0] model_q[$];
    bit            model_ovf = 1'b0;
    logic [PW-1:0] exp_q[$];

    typedef struct {
        bit            v;
        logic [NW-1:0] n;
        bit            fa;
        bit            fc;
        int            ec;
        logic [NW-1:0] eh;
        bit            eo;
    } vec_t;

    vec_t vecs[6];

    nonce_report_fifo #(.NONCE_WIDTH(NW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .nonce_valid     (nonce_valid),
        .nonce           (nonce),
        .host_ack_toggle (host_ack_toggle),
        .host_clr_toggle (host_clr_toggle),
        .probe_data      (probe_data)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] model_probe();
        int sz;
        logic [NW-1:0] h;
        sz = model_q.size();
        h  = (sz != 0) ? model_q[0] : '0;
        return {model_ovf, (sz != 0), 4'(sz), h};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // One clock cycle of stimulus; the model predicts, the scoreboard compares.
    task automatic step(input string name, input bit v, input logic [NW-1:0] n,
                        input bit fa, input bit fc);
        bit pop;
        @(negedge clk);
        nonce_valid = v;
        nonce       = n;
        if (fa) host_ack_toggle = ~host_ack_toggle;
        if (fc) host_clr_toggle = ~host_clr_toggle;
        pop = fa && (model_q.size() != 0);
        if (pop) void'(model_q.pop_front());
        if (v) begin
            if (model_q.size() < DEPTH) model_q.push_back(n);
            else model_ovf = 1'b1;
        end
        if (fc && !(v && model_q.size() == DEPTH && !pop && model_ovf)) begin
            // clear applies unless an overflow happened this same cycle
        end
        exp_q.push_back(model_probe());
        @(posedge clk);
        #1;
        nonce_valid = 1'b0;
        check(name, 64'(probe_data), 64'(exp_q.pop_front()));
    endtask

    // Overflow bookkeeping needs the pre-push occupancy, so wrap step().
    task automatic step_m(input string name, input bit v, input logic [NW-1:0] n,
                          input bit fa, input bit fc);
        bit ovf_evt;
        ovf_evt = v && (model_q.size() == DEPTH) && !fa;
        if (fc && !ovf_evt) model_ovf = 1'b0;
        step(name, v, n, fa, fc);
    endtask

    task automatic do_reset(input string name, input bit ack_lvl);
        @(negedge clk);
        reset = 1'b1;
        nonce_valid = 1'b0;
        host_ack_toggle = ack_lvl;
        model_q.delete();
        model_ovf = 1'b0;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        check(name, 64'(probe_data), 64'(exp_q.pop_front()));
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [NW-1:0] last_head;
    bit            saw9;

    initial begin
        reset = 1'b1;
        nonce_valid = 1'b0;
        nonce = '0;
        host_ack_toggle = 1'b0;
        host_clr_toggle = 1'b0;

        vecs[0] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1, 32'h11111111, 1'b0};
        vecs[1] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 2, 32'h11111111, 1'b0};
        vecs[2] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 3, 32'h11111111, 1'b0};
        vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 2, 32'h22222222, 1'b0};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 1, 32'h33333333, 1'b0};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 0, 32'h00000000, 1'b0};

        repeat (2) @(posedge clk);
        do_reset("reset_state", 1'b0);

        // Basic push/pop from the vector table
        for (int i = 0; i < 6; i++) begin
            step_m($sformatf("vec%0d_sb", i), vecs[i].v, vecs[i].n, vecs[i].fa, vecs[i].fc);
            check($sformatf("vec%0d_count", i), 64'(probe_data[NW +: 4]), 64'(vecs[i].ec));
            check($sformatf("vec%0d_valid", i), 64'(probe_data[NW+4]), 64'(vecs[i].ec != 0));
            check($sformatf("vec%0d_head", i), 64'(probe_data[NW-1:0]), 64'(vecs[i].eh));
            check($sformatf("vec%0d_ovf", i), 64'(probe_data[PW-1]), 64'(vecs[i].eo));
        end

        // Nine pushes with no pops: ninth is dropped, overflow sets
        for (int i = 1; i <= 9; i++) step_m($sformatf("fill9_%0d", i), 1'b1, NW'(i), 1'b0, 1'b0);
        check("fill9_count", 64'(probe_data[NW +: 4]), 64'd8);
        check("fill9_ovf", 64'(probe_data[PW-1]), 64'd1);
        check("fill9_head", 64'(probe_data[NW-1:0]), 64'h1);
        last_head = '0;
        saw9 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step_m($sformatf("drain_%0d", i), 1'b0, '0, 1'b1, 1'b0);
            if (probe_data[NW-1:0] == 32'h9) saw9 = 1'b1;
            if (probe_data[NW +: 4] != 4'd0) last_head = probe_data[NW-1:0];
        end
        check("drain_last_head", 64'(last_head), 64'h8);
        check("drain_no_nine", 64'(saw9), 64'd0);

        // Full FIFO, simultaneous push and pop
        step_m("clr_ovf", 1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf_flag", 64'(probe_data[PW-1]), 64'd0);
        for (int i = 0; i < 8; i++) step_m($sformatf("fill8_%0d", i), 1'b1, 32'h100 + NW'(i), 1'b0, 1'b0);
        step_m("full_push_pop", 1'b1, 32'hAAAAAAAA, 1'b1, 1'b0);
        check("full_pp_count", 64'(probe_data[NW +: 4]), 64'd8);
        check("full_pp_ovf", 64'(probe_data[PW-1]), 64'd0);
        check("full_pp_head", 64'(probe_data[NW-1:0]), 64'h101);
        for (int i = 0; i < 7; i++) step_m($sformatf("pp_drain_%0d", i), 1'b0, '0, 1'b1, 1'b0);
        check("pp_final_head", 64'(probe_data[NW-1:0]), 64'hAAAAAAAA);
        check("pp_final_count", 64'(probe_data[NW +: 4]), 64'd1);
        step_m("pp_drain_last", 1'b0, '0, 1'b1, 1'b0);

        // Empty FIFO: a discarded ack is not remembered
        step_m("empty_ack", 1'b0, '0, 1'b1, 1'b0);
        step_m("push_after_ack", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        check("dead_count", 64'(probe_data[NW +: 4]), 64'd1);
        check("dead_head", 64'(probe_data[NW-1:0]), 64'hDEADBEEF);
        step_m("empty_push_and_ack", 1'b1, 32'h12345678, 1'b1, 1'b0);
        check("mid_pp_count", 64'(probe_data[NW +: 4]), 64'd1);
        check("mid_pp_head", 64'(probe_data[NW-1:0]), 64'h12345678);
        step_m("dead_pop", 1'b0, '0, 1'b1, 1'b0);
        step_m("empty_pp", 1'b1, 32'hCAFE0001, 1'b1, 1'b0);
        check("empty_pp_count", 64'(probe_data[NW +: 4]), 64'd1);

        // Overflow set wins over a simultaneous clear
        for (int i = 0; i < 7; i++) step_m($sformatf("refill_%0d", i), 1'b1, 32'h200 + NW'(i), 1'b0, 1'b0);
        step_m("ovf_push", 1'b1, 32'hBAD00001, 1'b0, 1'b0);
        check("ovf_set", 64'(probe_data[PW-1]), 64'd1);
        step_m("ovf_and_clr", 1'b1, 32'hBAD00002, 1'b0, 1'b1);
        check("ovf_set_wins", 64'(probe_data[PW-1]), 64'd1);
        step_m("clr_alone", 1'b0, '0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(probe_data[PW-1]), 64'd0);
        step_m("clr_steady", 1'b0, '0, 1'b0, 1'b0);

        // Reset mid-operation with ack level changing to 1 during reset
        do_reset("reset_pre", 1'b0);
        step_m("rst_load_a", 1'b1, 32'h0000AAAA, 1'b0, 1'b0);
        step_m("rst_load_b", 1'b1, 32'h0000BBBB, 1'b0, 1'b0);
        check("rst_loaded", 64'(probe_data[NW +: 4]), 64'd2);
        do_reset("reset_mid", 1'b1);
        step_m("rst_idle", 1'b0, '0, 1'b0, 1'b0);
        check("rst_count0", 64'(probe_data[NW +: 4]), 64'd0);
        step_m("rst_push", 1'b1, 32'h0000CCCC, 1'b0, 1'b0);
        check("rst_push_count", 64'(probe_data[NW +: 4]), 64'd1);
        check("rst_push_head", 64'(probe_data[NW-1:0]), 64'h0000CCCC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
